// File: rtl/zjh_cmp_serial.sv
// Nibble-serial WIDTH-bit magnitude comparator with 74HC85-style cascade inputs and registered results.
// Optional ZJH_CMP_MSB_EARLY_EN: MSB-first scan that finishes on the first differing nibble.
module zjh_cmp_serial #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             IAGB,
  input  logic             IASB,
  input  logic             IAEB,
  output logic             BUSY,
  output logic             DONE,
  output logic             QAGB,
  output logic             QASB,
  output logic             QAEB
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [NIBBLES-1:0][3:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    decided_q, decided_d, gt_q, gt_d, lt_q, lt_d;
  logic                    cgt_q, cgt_d, clt_q, clt_d, ceq_q, ceq_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    qagb_q, qagb_d, qasb_q, qasb_d, qaeb_q, qaeb_d;

  logic [3:0] a_nib, b_nib;
  logic       nib_diff, dec_n, gt_n, lt_n, last;

  always_comb begin
    a_nib    = a_q[idx_q];
    b_nib    = b_q[idx_q];
    nib_diff = (a_nib != b_nib);
    // A differing nibble overwrites the accumulator; equal ones leave it alone.
    dec_n    = decided_q | nib_diff;
    gt_n     = nib_diff ? (a_nib > b_nib) : gt_q;
    lt_n     = nib_diff ? (a_nib < b_nib) : lt_q;
`ifdef ZJH_CMP_MSB_EARLY_EN
    last     = nib_diff || (idx_q == '0);
`else
    last     = (idx_q == IW'(NIBBLES - 1));
`endif

    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    cgt_d     = cgt_q;
    clt_d     = clt_q;
    ceq_d     = ceq_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    qagb_d    = qagb_q;
    qasb_d    = qasb_q;
    qaeb_d    = qaeb_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          a_d       = A;
          b_d       = B;
          cgt_d     = IAGB;
          clt_d     = IASB;
          ceq_d     = IAEB;
          decided_d = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
`ifdef ZJH_CMP_MSB_EARLY_EN
          idx_d     = IW'(NIBBLES - 1);
`else
          idx_d     = '0;
`endif
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        decided_d = dec_n;
        gt_d      = gt_n;
        lt_d      = lt_n;
`ifdef ZJH_CMP_MSB_EARLY_EN
        idx_d     = idx_q - IW'(1);
`else
        idx_d     = idx_q + IW'(1);
`endif
        if (last) begin
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
          // Cascade inputs only matter when every nibble matched.
          if (dec_n) begin
            qagb_d = gt_n;
            qasb_d = lt_n;
            qaeb_d = 1'b0;
          end else if (ceq_q) begin
            qagb_d = 1'b0;
            qasb_d = 1'b0;
            qaeb_d = 1'b1;
          end else begin
            qagb_d = ~clt_q;
            qasb_d = ~cgt_q;
            qaeb_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      cgt_q     <= 1'b0;
      clt_q     <= 1'b0;
      ceq_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      qagb_q    <= 1'b0;
      qasb_q    <= 1'b0;
      qaeb_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      cgt_q     <= cgt_d;
      clt_q     <= clt_d;
      ceq_q     <= ceq_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      qagb_q    <= qagb_d;
      qasb_q    <= qasb_d;
      qaeb_q    <= qaeb_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign QAGB = qagb_q;
  assign QASB = qasb_q;
  assign QAEB = qaeb_q;

endmodule
